// File: rtl/systolic_slice_feeder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | systolic_slice_feeder                                                     |
// | Streams NUM_CH matrices slice by slice from memory into a systolic array. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module systolic_slice_feeder #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_CH       = 2,
  parameter int SLICE_LEN    = 32,
  parameter int SLICE_STRIDE = 32
) (
  input  logic                         s_clk,
  input  logic                         s_rst,
  input  logic                         start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base,
  input  logic [15:0]                  cfg_slice_num,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_CH-1:0]            rd_en,
  output logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]            m_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
  output logic [NUM_CH-1:0]            m_last,
  input  logic [NUM_CH-1:0]            m_ready,
  output logic [NUM_CH-1:0]            slice_done
);

  localparam int                    c_WORD_W    = (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;
  localparam logic [c_WORD_W-1:0]   c_LAST_WORD = c_WORD_W'(SLICE_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] c_STRIDE    = ADDR_WIDTH'(SLICE_STRIDE);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIN  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic [15:0]       r_sliceNum;
  logic              r_zeroDone;
  logic              w_accept;
  logic              w_run;
  logic [NUM_CH-1:0] w_chFin;

  assign w_accept = start && (r_state == c_IDLE) && (cfg_slice_num != 16'd0);
  assign w_run    = (r_state == c_RUN);

  always_ff @(posedge s_clk) begin
    if (s_rst) r_state <= c_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_nextState = c_RUN;
      c_RUN:   if (&w_chFin) w_nextState = c_FIN;
      c_FIN:   w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != c_IDLE);
    done = (r_state == c_FIN) || r_zeroDone;
  end

  // An empty pass never leaves IDLE; it only answers with a done pulse.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_sliceNum <= 16'd0;
      r_zeroDone <= 1'b0;
    end else begin
      r_zeroDone <= start && (r_state == c_IDLE) && (cfg_slice_num == 16'd0);
      if (w_accept) r_sliceNum <= cfg_slice_num;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [c_WORD_W-1:0]   r_wordIdx;
    logic [15:0]           r_sliceIdx;
    logic [ADDR_WIDTH-1:0] r_sliceBase;
    logic                  r_issueDone;
    logic                  r_inFlight;
    logic                  r_inFlightLast;
    logic                  r_chFin;
    logic                  r_sliceDone;
    logic [DATA_WIDTH:0]   r_mem [2];
    logic                  r_wrPtr;
    logic                  r_rdPtr;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_rdEn;
    logic                  w_finalPop;
    logic                  w_lastOut;
    logic [2:0]            w_level;

    // Returning read data falls through to the stream when the FIFO is empty,
    // which keeps first-beat latency at two cycles after start.
    assign w_head     = r_mem[r_rdPtr];
    assign w_valid    = (r_occ != 2'd0) || r_inFlight;
    assign w_pop      = w_valid && m_ready[k];
    assign w_push     = r_inFlight && !((r_occ == 2'd0) && w_pop);
    assign w_level    = 3'(r_occ) + 3'(r_inFlight) - 3'(w_pop);
    assign w_rdEn     = w_run && !r_issueDone && (w_level < 3'd2);
    assign w_finalPop = w_pop && r_issueDone && ((3'(r_occ) + 3'(r_inFlight)) == 3'd1);
    assign w_lastOut  = (r_occ != 2'd0) ? w_head[DATA_WIDTH] : (r_inFlight && r_inFlightLast);

    always_ff @(posedge s_clk) begin
      if (s_rst) begin
        r_wordIdx   <= '0;
        r_sliceIdx  <= 16'd0;
        r_sliceBase <= '0;
        r_issueDone <= 1'b0;
      end else if (w_accept) begin
        r_wordIdx   <= '0;
        r_sliceIdx  <= 16'd0;
        r_sliceBase <= cfg_base[k*ADDR_WIDTH +: ADDR_WIDTH];
        r_issueDone <= 1'b0;
      end else if (w_rdEn) begin
        if (r_wordIdx == c_LAST_WORD) begin
          r_wordIdx   <= '0;
          r_sliceBase <= r_sliceBase + c_STRIDE;
          if (r_sliceIdx == r_sliceNum - 16'd1) r_issueDone <= 1'b1;
          else                                  r_sliceIdx  <= r_sliceIdx + 16'd1;
        end else begin
          r_wordIdx <= r_wordIdx + 1'b1;
        end
      end
    end

    always_ff @(posedge s_clk) begin
      if (s_rst) begin
        r_inFlight     <= 1'b0;
        r_inFlightLast <= 1'b0;
        r_wrPtr        <= 1'b0;
        r_rdPtr        <= 1'b0;
        r_occ          <= 2'd0;
        r_sliceDone    <= 1'b0;
        r_chFin        <= 1'b0;
      end else begin
        r_inFlight     <= w_rdEn;
        r_inFlightLast <= (r_wordIdx == c_LAST_WORD);
        r_sliceDone    <= w_pop && w_lastOut;
        if (w_push) r_wrPtr <= ~r_wrPtr;
        if (w_pop && (r_occ != 2'd0)) r_rdPtr <= ~r_rdPtr;
        r_occ <= r_occ + 2'(w_push) - 2'(w_pop && (r_occ != 2'd0));
        if (w_accept)        r_chFin <= 1'b0;
        else if (w_finalPop) r_chFin <= 1'b1;
      end
    end

    always_ff @(posedge s_clk) begin
      if (w_push) r_mem[r_wrPtr] <= {r_inFlightLast, rd_data[k*DATA_WIDTH +: DATA_WIDTH]};
    end

    assign w_chFin[k]                            = r_chFin || w_finalPop;
    assign rd_en[k]                              = w_rdEn;
    assign rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]   = r_sliceBase + ADDR_WIDTH'(r_wordIdx);
    assign m_valid[k]                            = w_valid;
    assign m_last[k]                             = w_lastOut;
    assign slice_done[k]                         = r_sliceDone;
    assign m_data[k*DATA_WIDTH +: DATA_WIDTH]    = (r_occ != 2'd0) ? w_head[DATA_WIDTH-1:0] :
                                                   (r_inFlight ? rd_data[k*DATA_WIDTH +: DATA_WIDTH]
                                                               : {DATA_WIDTH{1'b0}});
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_slice_feeder.sv
`default_nettype none
// Testbench for systolic_slice_feeder: table of pass configurations checked
// against a per-channel address/beat scoreboard, plus a mid-pass reset sequence.
`timescale 1ns/1ps
module tb_systolic_slice_feeder;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int NC = 2;
  localparam int SL = 32;
  localparam int SS = 32;

  logic             s_clk = 1'b0;
  logic             s_rst;
  logic             start;
  logic [NC*AW-1:0] cfg_base;
  logic [15:0]      cfg_slice_num;
  logic             busy, done;
  logic [NC-1:0]    rd_en;
  logic [NC*AW-1:0] rd_addr;
  logic [NC*DW-1:0] rd_data;
  logic [NC-1:0]    m_valid, m_last, m_ready, slice_done;
  logic [NC*DW-1:0] m_data;

  systolic_slice_feeder dut (
    .s_clk(s_clk), .s_rst(s_rst), .start(start), .cfg_base(cfg_base),
    .cfg_slice_num(cfg_slice_num), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .slice_done(slice_done)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    logic [15:0] base0;
    logic [15:0] base1;
    logic [15:0] slices;
    int          stallCh;
    bit          restart;
    int          expBeats;
    int          expSliceDone;
    int          expDone;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  vec_t          vecs [5];
  beat_t         expQ [NC][$];
  logic [AW-1:0] addrQ [NC][$];

  int checks = 0, errors = 0, cyc = 0;
  int beats[NC], sdCnt[NC], rdCnt[NC], firstV[NC], lastB[NC];
  int doneCnt = 0, doneCyc = -1, busyCnt = 0;
  bit sbOn = 1'b0;
  bit readyHi = 1'b1;
  int stallCh = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [DW-1:0] memWord(int k, logic [AW-1:0] a);
    logic [15:0] tag;
    tag = 16'(k + 1) * 16'h1111;
    return {tag, a, ~a, a ^ 16'h5A5A};
  endfunction

  always @(posedge s_clk) cyc <= cyc + 1;

  // Memory model: one-cycle read latency, junk on idle cycles.
  initial begin
    logic [NC-1:0]    en;
    logic [NC*AW-1:0] ad;
    rd_data = '0;
    forever begin
      @(negedge s_clk);
      en = rd_en;
      ad = rd_addr;
      @(posedge s_clk);
      #1;
      for (int k = 0; k < NC; k++)
        rd_data[k*DW +: DW] = en[k] ? memWord(k, ad[k*AW +: AW]) : {$urandom, $urandom};
    end
  end

  // Ready driver: one optionally stalled channel toggles randomly.
  initial begin
    m_ready = '1;
    forever begin
      @(posedge s_clk);
      #1;
      for (int k = 0; k < NC; k++)
        m_ready[k] = (k == stallCh) ? 1'($urandom_range(0, 1)) : readyHi;
    end
  end

  // Monitor and scoreboard.
  always @(negedge s_clk) begin
    beat_t b;
    if (busy) busyCnt++;
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
    end
    for (int k = 0; k < NC; k++) begin
      if (slice_done[k]) sdCnt[k]++;
      if (rd_en[k]) begin
        rdCnt[k]++;
        if (sbOn) begin
          if (addrQ[k].size() == 0) chk("rd_addr_unexpected", 64'd1, 64'd0);
          else                      chk("rd_addr", 64'(rd_addr[k*AW +: AW]), 64'(addrQ[k].pop_front()));
        end
      end
      if (m_valid[k] && sbOn) begin
        if (firstV[k] < 0) firstV[k] = cyc;
        if (expQ[k].size() == 0) begin
          chk("beat_unexpected", 64'd1, 64'd0);
        end else begin
          b = expQ[k][0];
          chk("m_data", m_data[k*DW +: DW], b.data);
          chk("m_last", 64'(m_last[k]), 64'(b.last));
          if (m_ready[k]) begin
            void'(expQ[k].pop_front());
            beats[k]++;
            lastB[k] = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic startPass(vec_t v, output int sCyc);
    beat_t         b;
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    for (int k = 0; k < NC; k++) begin
      beats[k] = 0; sdCnt[k] = 0; rdCnt[k] = 0; firstV[k] = -1; lastB[k] = -1;
      expQ[k].delete();
      addrQ[k].delete();
      base = (k == 0) ? v.base0 : v.base1;
      for (int s = 0; s < int'(v.slices); s++)
        for (int w = 0; w < SL; w++) begin
          a = base + AW'(s * SS) + AW'(w);
          addrQ[k].push_back(a);
          b.data = memWord(k, a);
          b.last = (w == SL - 1);
          expQ[k].push_back(b);
        end
    end
    doneCnt = 0; doneCyc = -1; busyCnt = 0;
    stallCh = v.stallCh;
    sbOn    = 1'b1;
    tick();
    start = 1'b1;
    cfg_base = {v.base1, v.base0};
    cfg_slice_num = v.slices;
    sCyc = cyc;
    tick();
    start = 1'b0;
    cfg_base = {$urandom, $urandom};
    cfg_slice_num = 16'd7;
  endtask

  task automatic runPass(int i);
    vec_t v;
    int   sCyc, t, maxLast;
    v = vecs[i];
    startPass(v, sCyc);
    if (v.restart) begin
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    t = 0;
    while (doneCnt == 0 && t < 3000) begin
      tick();
      t++;
    end
    chk("done_seen", 64'(doneCnt > 0), 64'd1);
    repeat (4) tick();
    stallCh = -1;
    chk("done_count", 64'(doneCnt), 64'(v.expDone));
    maxLast = -1;
    for (int k = 0; k < NC; k++) begin
      chk("beat_count", 64'(beats[k]), 64'(v.expBeats));
      chk("read_count", 64'(rdCnt[k]), 64'(v.expBeats));
      chk("slice_done_count", 64'(sdCnt[k]), 64'(v.expSliceDone));
      chk("scoreboard_empty", 64'(expQ[k].size()), 64'd0);
      if (lastB[k] > maxLast) maxLast = lastB[k];
    end
    if (v.slices == 16'd0) begin
      chk("zero_done_latency", 64'(doneCyc - sCyc), 64'd1);
      chk("zero_busy_cycles", 64'(busyCnt), 64'd0);
    end else begin
      chk("done_after_last", 64'(doneCyc - maxLast), 64'd1);
      chk("busy_cycles", 64'(busyCnt), 64'(doneCyc - sCyc));
      for (int k = 0; k < NC; k++) begin
        chk("first_valid_latency", 64'(firstV[k] - sCyc), 64'd2);
        if (k != v.stallCh) chk("gapless_stream", 64'(lastB[k] - firstV[k]), 64'(v.expBeats - 1));
      end
      if (v.stallCh >= 0)
        chk("stalled_ch_finishes_last", 64'(lastB[v.stallCh] > lastB[1 - v.stallCh]), 64'd1);
    end
  endtask

  initial begin
    int sCyc, t;
    vecs[0] = '{16'h0000, 16'h0100, 16'd2, -1, 1'b0, 64, 2, 1};
    vecs[1] = '{16'h0000, 16'h0100, 16'd2,  0, 1'b1, 64, 2, 1};
    vecs[2] = '{16'hFFF0, 16'h1234, 16'd1, -1, 1'b0, 32, 1, 1};
    vecs[3] = '{16'h0040, 16'h0080, 16'd0, -1, 1'b0,  0, 0, 1};
    vecs[4] = '{16'h8000, 16'hFFE8, 16'd3,  1, 1'b0, 96, 3, 1};

    s_rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_slice_num = 16'd0;
    repeat (3) tick();
    @(negedge s_clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rd_en", 64'(rd_en), 64'd0);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    tick();
    s_rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) runPass(i);

    // Mid-pass reset with the stream stalled.
    startPass(vecs[0], sCyc);
    t = 0;
    while (beats[0] < 10 && t < 500) begin
      tick();
      t++;
    end
    chk("reached_beat_10", 64'(beats[0] >= 10), 64'd1);
    readyHi = 1'b0;
    repeat (2) tick();
    sbOn  = 1'b0;
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    @(negedge s_clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_slice_done", 64'(slice_done), 64'd0);
    chk("rst_m_data", 64'(m_data != '0), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    repeat (10) tick();
    chk("rst_no_done", 64'(doneCnt), 64'd0);
    chk("rst_stays_idle", 64'(busy), 64'd0);
    readyHi = 1'b1;
    repeat (2) tick();
    runPass(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/systolic_slice_feeder.md
SYSTOLIC_SLICE_FEEDER -- requirements
Module: systolic_slice_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the width of one memory word and one stream beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning the word-address width.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning the number of independent matrix channels (A, B, ...).
REQ-004 SHALL have parameter SLICE_LEN, default 32, meaning the number of words per slice.
REQ-005 SHALL have parameter SLICE_STRIDE, default 32, meaning the address step between consecutive slices.
REQ-006 s_clk  in  1  sole clock; all logic on rising edge.
REQ-007 s_rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle pulse that begins a pass.
REQ-009 cfg_base  in  NUM_CH*ADDR_WIDTH  per-channel base word address; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 cfg_slice_num  in  16  number of slices per channel in the pass.
REQ-011 busy  out  1  high while a pass is in progress.
REQ-012 done  out  1  one-cycle pulse when all channels have finished the pass.
REQ-013 rd_en  out  NUM_CH  per-channel memory read strobe.
REQ-014 rd_addr  out  NUM_CH*ADDR_WIDTH  per-channel read address.
REQ-015 rd_data  in  NUM_CH*DATA_WIDTH  per-channel read data, valid exactly 1 cycle after rd_en.
REQ-016 m_valid  out  NUM_CH  per-channel stream valid.
REQ-017 m_data  out  NUM_CH*DATA_WIDTH  per-channel stream data.
REQ-018 m_last  out  NUM_CH  high on the final beat of each slice.
REQ-019 m_ready  in  NUM_CH  per-channel stream ready from the systolic array.
REQ-020 slice_done  out  NUM_CH  one-cycle pulse in the cycle after the handshake of a beat with m_last high.

Function
REQ-021 FSM SHALL have states IDLE, RUN and FIN; IDLE->RUN on start when cfg_slice_num>0; RUN->FIN when every channel has handshaken its final beat; FIN->IDLE unconditionally after 1 cycle, pulsing done in FIN.
REQ-022 start in IDLE with cfg_slice_num==0 SHALL pulse done in the next cycle and issue no reads; start outside IDLE SHALL be ignored.
REQ-023 cfg_base and cfg_slice_num SHALL be registered on an accepted start; later changes SHALL have no effect on the current pass.
REQ-024 Channel k, slice s, word w SHALL read address base_k + s*SLICE_STRIDE + w, truncated modulo 2^ADDR_WIDTH; words are issued in the order w=0..SLICE_LEN-1, then s=0..cfg_slice_num-1.
REQ-025 Each channel SHALL have a 2-entry output FIFO; rd_en[k] SHALL assert only when (occupancy + in-flight - pop this cycle) < 2 and unissued words remain.
REQ-026 With m_ready held high, each channel SHALL sustain 1 beat per cycle; the first m_valid SHALL rise 2 cycles after start.
REQ-027 A beat SHALL transfer when m_valid&m_ready; while m_valid is high and m_ready is low, m_data and m_last SHALL be held stable and no FIFO entry SHALL be lost or duplicated.
REQ-028 Channels SHALL progress independently; a stalled channel SHALL NOT stall the others; done SHALL wait for the slowest channel.
REQ-029 busy SHALL be high from the cycle after an accepted start through the FIN cycle, inclusive.

Reset
REQ-030 s_rst SHALL force state IDLE and clear busy, done, rd_en, m_valid, m_last, slice_done, all counters, FIFOs and in-flight flags to 0.
REQ-031 Reset mid-pass SHALL abort the pass: rd_data returning in the cycle after reset SHALL be discarded, and no done pulse SHALL be produced.

Verification
REQ-032 Defaults, cfg_base={0x0100,0x0000}, cfg_slice_num=2, m_ready=all 1 -> each channel emits 64 beats with no gaps; ch0 addresses 0x0000..0x003F; m_last on beats 31 and 63; 2 slice_done pulses per channel; done exactly once.
REQ-033 Same configuration with m_ready[0] toggling on a random 50% pattern -> ch0 data sequence is identical to the unstalled run and data stays stable while stalled; ch1 finishes first and done follows ch0's final beat by 1 cycle.
REQ-034 cfg_base[0]=0xFFF0, cfg_slice_num=1 -> ch0 addresses 0xFFF0..0xFFFF followed by 0x0000..0x000F.
REQ-035 cfg_slice_num=0 -> done pulses the cycle after start, rd_en never asserts, busy stays 0.
REQ-036 Assert s_rst for 1 cycle after beat 10 of a run with m_ready low -> all outputs are 0 the next cycle; a subsequent start produces a clean full pass beginning at word 0.
